// File: rtl/db9md_pad_scanner.sv
// db9md_pad_scanner
// Time-multiplexed reader for two Mega Drive 3/6-button pads sharing one set
// of data pins. Each scan drives an 8-step SELECT sequence on the currently
// selected port, captures the pad's answers into a shadow register, and
// commits a complete active-high word for that port in a single cycle. The
// port-split line then flips so the two ports are scanned alternately.
module db9md_pad_scanner #(
  parameter int STEP_CYCLES = 480,   // clk cycles per SELECT half-step, 4..65535
  parameter int IDLE_CYCLES = 48000  // SELECT-high gap between scans, 4..65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  present,
  output logic [1:0]  six_btn,
  output logic        scan_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STEP   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [15:0] STEP_LOAD  = 16'(STEP_CYCLES);
  localparam logic [15:0] IDLE_LOAD  = 16'(IDLE_CYCLES);
  // After reset the counter reads 0; that cycle already counts as the first
  // IDLE cycle, so only IDLE_CYCLES-1 further cycles are loaded.
  localparam logic [15:0] IDLE_FIRST = 16'(IDLE_CYCLES - 1);

  logic [5:0]  sync1;
  logic [5:0]  s;        // synchronized pins, active-low
  logic [5:0]  p;        // pressed view, active-high
  logic [1:0]  state;
  logic [2:0]  step;
  logic [15:0] count;
  logic        terminal;

  // Shadow of the scan in progress, stored in final word bit order
  // ([0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z).
  logic [11:0] sh_btn;
  logic        sh_pres;
  logic        sh_six;
  logic [15:0] word;

  assign p        = ~s;
  assign terminal = (count == 16'd1);
  assign word     = sh_pres ? {4'b0000, (sh_six ? sh_btn[11:8] : 4'b0000), sh_btn[7:0]}
                            : 16'h0000;

  // Two-flop synchronizer for the asynchronous pad pins (idle level is high).
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment uses <= so all flops update from
    // pre-edge values; blocking here would collapse the two sync stages.
    if (reset) begin
      sync1 <= '1;
      s     <= '1;
    end else begin
      sync1 <= joy_in;
      s     <= sync1;
    end
  end

  // Scan sequencer: IDLE -> STEP0..STEP7 -> COMMIT, with registered SELECT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      step      <= 3'd0;
      count     <= 16'd0;
      joy_mdsel <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count == 16'd0) begin
            count <= IDLE_FIRST;
          end else if (terminal) begin
            state     <= ST_STEP;
            step      <= 3'd0;
            count     <= STEP_LOAD;
            joy_mdsel <= 1'b1;
          end else begin
            count <= count - 16'd1;
          end
        end
        ST_STEP: begin
          if (terminal) begin
            if (step == 3'd7) begin
              state     <= ST_COMMIT;
              joy_mdsel <= 1'b1;
            end else begin
              step      <= step + 3'd1;
              count     <= STEP_LOAD;
              // Next step is odd (SELECT low) exactly when this one is even.
              joy_mdsel <= step[0];
            end
          end else begin
            count <= count - 16'd1;
          end
        end
        ST_COMMIT: begin
          state     <= ST_IDLE;
          count     <= IDLE_LOAD;
          joy_mdsel <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          step      <= 3'd0;
          count     <= 16'd0;
          joy_mdsel <= 1'b1;
        end
      endcase
    end
  end

  // Shadow capture on the last cycle of each step that carries pad data.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_btn  <= 12'h000;
      sh_pres <= 1'b0;
      sh_six  <= 1'b0;
    end else if (state == ST_STEP && terminal) begin
      case (step)
        3'd0: sh_btn[5:0]  <= {p[5], p[4], p[0], p[1], p[2], p[3]};
        3'd1: begin
          // A pad answers SELECT-low by pulling Left and Right low.
          sh_pres     <= (s[3:2] == 2'b00);
          sh_btn[7:6] <= {p[5], p[4]};
        end
        // A 6-button pad pulls all four directions low on the third low phase.
        3'd5: sh_six <= (s[3:0] == 4'b0000);
        3'd6: sh_btn[11:8] <= {p[0], p[1], p[2], p[3]};
        default: ;
      endcase
    end
  end

  // Commit the finished scan to the selected port and flip the port split.
  always_ff @(posedge clk) begin
    if (reset) begin
      joystick1 <= 16'h0000;
      joystick2 <= 16'h0000;
      present   <= 2'b00;
      six_btn   <= 2'b00;
      scan_done <= 1'b0;
      joy_split <= 1'b1;
    end else begin
      scan_done <= 1'b0;
      if (state == ST_COMMIT) begin
        scan_done <= 1'b1;
        joy_split <= ~joy_split;
        if (joy_split) begin
          joystick1  <= word;
          present[0] <= sh_pres;
          six_btn[0] <= sh_pres & sh_six;
        end else begin
          joystick2  <= word;
          present[1] <= sh_pres;
          six_btn[1] <= sh_pres & sh_six;
        end
      end
    end
  end

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// tb_db9md_pad_scanner
// Mock Mega Drive pads answer the scanner's SELECT/split lines; a cycle-count
// model derived from the scan period predicts every output on every cycle.
module tb_db9md_pad_scanner;

  localparam int STEP   = 4;
  localparam int IDLE   = 16;
  localparam int PERIOD = IDLE + 8 * STEP + 1;  // 49 cycles per port

  typedef enum logic [1:0] {PAD_NONE, PAD_3BTN, PAD_6BTN} pad_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  present;
  logic [1:0]  six_btn;
  logic        scan_done;

  always #5 clk = ~clk;

  db9md_pad_scanner #(
    .STEP_CYCLES(STEP),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .joy_in    (joy_in),
    .joy_mdsel (joy_mdsel),
    .joy_split (joy_split),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .present   (present),
    .six_btn   (six_btn),
    .scan_done (scan_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- mock pads ----------------
  pad_t        type1 = PAD_NONE;
  pad_t        type2 = PAD_NONE;
  logic [11:0] btn1  = 12'h000;
  logic [11:0] btn2  = 12'h000;

  // Shared SELECT falling-edge counter; a long SELECT-high resets it.
  logic sel_d  = 1'b1;
  int   hi_run = 0;
  int   n_reg  = 0;
  int   n_eff;

  always_comb n_eff = n_reg + ((sel_d && !joy_mdsel) ? 1 : 0);

  always @(posedge clk) begin
    if (reset) begin
      sel_d  <= 1'b1;
      hi_run <= 0;
      n_reg  <= 0;
    end else begin
      sel_d  <= joy_mdsel;
      hi_run <= joy_mdsel ? hi_run + 1 : 0;
      n_reg  <= (joy_mdsel && hi_run >= 8) ? 0 : n_eff;
    end
  end

  // Pins are active-low: [0]Up [1]Down [2]Left [3]Right [4]TL [5]TR.
  function automatic logic [5:0] pad_pins(input pad_t t, input logic [11:0] b,
                                          input logic sel, input int n);
    if (t == PAD_NONE) return 6'h3F;
    if (sel) begin
      if (t == PAD_6BTN && n == 3) return ~{b[5], b[4], b[8], b[9], b[10], b[11]};
      return ~{b[5], b[4], b[0], b[1], b[2], b[3]};
    end
    if (t == PAD_6BTN && n == 3) return ~{b[7], b[6], 4'b1111};
    if (t == PAD_6BTN && n == 4) return ~{b[7], b[6], 4'b0000};
    return ~{b[7], b[6], 2'b11, b[2], b[3]};
  endfunction

  always_comb joy_in = joy_split ? pad_pins(type1, btn1, joy_mdsel, n_eff)
                                 : pad_pins(type2, btn2, joy_mdsel, n_eff);

  // ---------------- reference model ----------------
  function automatic logic [15:0] expect_word(input pad_t t, input logic [11:0] b);
    case (t)
      PAD_3BTN: return {8'h00, b[7:0]};
      PAD_6BTN: return {4'h0, b};
      default:  return 16'h0000;
    endcase
  endfunction

  int          t = 0;           // cycles since the last reset edge
  logic        model_valid = 1'b0;
  logic [15:0] exp_j1, exp_j2;
  logic [1:0]  exp_pres, exp_six;
  logic        exp_split, exp_done;

  always @(posedge clk) begin
    if (reset) begin
      t           <= 0;
      model_valid <= 1'b1;
      exp_j1      <= 16'h0;
      exp_j2      <= 16'h0;
      exp_pres    <= 2'b00;
      exp_six     <= 2'b00;
      exp_split   <= 1'b1;
      exp_done    <= 1'b0;
    end else if (model_valid) begin
      t        <= t + 1;
      exp_done <= ((t + 1) % PERIOD == 0);
      if ((t + 1) % PERIOD == 0) begin
        if (exp_split) begin
          exp_j1      <= expect_word(type1, btn1);
          exp_pres[0] <= (type1 != PAD_NONE);
          exp_six[0]  <= (type1 == PAD_6BTN);
        end else begin
          exp_j2      <= expect_word(type2, btn2);
          exp_pres[1] <= (type2 != PAD_NONE);
          exp_six[1]  <= (type2 == PAD_6BTN);
        end
        exp_split <= ~exp_split;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int   pos;
  logic exp_mdsel;
  int   low_run    = 0;
  int   low_pulses = 0;

  always @(negedge clk) begin
    if (model_valid) begin
      pos       = t % PERIOD;
      exp_mdsel = !(pos >= IDLE && pos < IDLE + 8 * STEP && (((pos - IDLE) / STEP) % 2) == 1);
      check("joystick1", 32'(joystick1), 32'(exp_j1));
      check("joystick2", 32'(joystick2), 32'(exp_j2));
      check("present",   32'(present),   32'(exp_pres));
      check("six_btn",   32'(six_btn),   32'(exp_six));
      check("scan_done", 32'(scan_done), 32'(exp_done));
      check("joy_split", 32'(joy_split), 32'(exp_split));
      check("joy_mdsel", 32'(joy_mdsel), 32'(exp_mdsel));
      if (t == 0) begin
        low_run    = 0;
        low_pulses = 0;
      end
      if (!joy_mdsel) begin
        low_run++;
      end else if (low_run != 0) begin
        check("mdsel_low_width", 32'(low_run), 32'(STEP));
        low_pulses++;
        low_run = 0;
      end
      if (scan_done) begin
        check("mdsel_pulses_per_scan", 32'(low_pulses), 32'd4);
        low_pulses = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_cfg(input pad_t t1, input logic [11:0] b1,
                           input pad_t t2, input logic [11:0] b2);
    type1 = t1; btn1 = b1;
    type2 = t2; btn2 = b2;
  endtask

  task automatic wait_port();
    repeat (PERIOD) @(negedge clk);
  endtask

  task automatic random_refresh();
    logic [11:0] b1, b2;
    pad_t        t1, t2;
    t1 = pad_t'($urandom_range(0, 2));
    t2 = pad_t'($urandom_range(0, 2));
    b1 = 12'($urandom_range(0, 4095));
    b2 = 12'($urandom_range(0, 4095));
    if (b1[3] && b1[2]) b1[2] = 1'b0;  // a d-pad cannot press Up and Down together
    if (b2[3] && b2[2]) b2[2] = 1'b0;
    apply_cfg(t1, b1, t2, b2);
    wait_port();
    wait_port();
  endtask

  initial begin
    apply_cfg(PAD_NONE, 12'h000, PAD_NONE, 12'h000);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_joystick1", 32'(joystick1), 32'h0);
    check("rst_joystick2", 32'(joystick2), 32'h0);
    check("rst_present",   32'(present),   32'h0);
    check("rst_mdsel",     32'(joy_mdsel), 32'h1);
    check("rst_split",     32'(joy_split), 32'h1);
    reset = 1'b0;

    // No pads: pins float high.
    wait_port();
    check("t1_done", 32'(scan_done), 32'h1);
    check("t1_j1",   32'(joystick1), 32'h0);
    check("t1_split_after", 32'(joy_split), 32'h0);
    wait_port();
    check("t1_j2",   32'(joystick2), 32'h0);
    check("t1_pres", 32'(present),   32'h0);

    // 3-button pad on port 1, Up + A.
    apply_cfg(PAD_3BTN, 12'h048, PAD_NONE, 12'h000);
    wait_port();
    check("t2_j1",   32'(joystick1), 32'h0048);
    check("t2_pres", 32'(present[0]), 32'h1);
    check("t2_six",  32'(six_btn[0]), 32'h0);
    wait_port();

    // 6-button pad on port 1, Start + Mode + Z.
    apply_cfg(PAD_6BTN, 12'h980, PAD_NONE, 12'h000);
    wait_port();
    check("t3_j1",  32'(joystick1), 32'h0980);
    check("t3_six", 32'(six_btn[0]), 32'h1);
    wait_port();

    // Port 2 only: 3-button pad, Right.
    apply_cfg(PAD_NONE, 12'h000, PAD_3BTN, 12'h001);
    wait_port();
    check("t4_j1", 32'(joystick1), 32'h0);
    wait_port();
    check("t4_j2",   32'(joystick2), 32'h0001);
    check("t4_pres", 32'(present),   32'h2);

    for (int i = 0; i < 20; i++) random_refresh();

    // Reset pulsed during STEP3 of a port-1 scan.
    apply_cfg(PAD_6BTN, 12'hAB5, PAD_3BTN, 12'h0F0);
    wait_port();
    wait_port();
    repeat (IDLE + 3 * STEP + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_j1",    32'(joystick1), 32'h0);
    check("t5_j2",    32'(joystick2), 32'h0);
    check("t5_pres",  32'(present),   32'h0);
    check("t5_six",   32'(six_btn),   32'h0);
    check("t5_mdsel", 32'(joy_mdsel), 32'h1);
    check("t5_split", 32'(joy_split), 32'h1);
    check("t5_done0", 32'(scan_done), 32'h0);
    repeat (PERIOD - 1) @(negedge clk);
    check("t5_done_early", 32'(scan_done), 32'h0);
    @(negedge clk);
    check("t5_done_49", 32'(scan_done), 32'h1);
    check("t5_j1_after", 32'(joystick1), 32'h0AB5);
    wait_port();

    for (int i = 0; i < 4; i++) random_refresh();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
